arrow_judge: RTL

- Downstream consumer of the random arrow generator in the DDR game.
- On each metronome beat it latches the head arrow code. It then watches the player's debounced arrow buttons over a timing window and grades each arrow PERFECT, GOOD or MISS.
- Keeps a running score and combo, which are fed to the display/scoreboard logic.

---
 rtl/arrow_judge_pkg.sv | 22 ++
 rtl/arrow_judge_btn_edge_detect.sv | 26 ++
 rtl/arrow_judge.sv | 118 +++++++++++
 3 files changed

// File: rtl/arrow_judge_pkg.sv
// Shared DDR definitions for the arrow judge: lane count, grade and state
// encodings, and default point values.
package arrow_judge_pkg;

  localparam int NUM_ARROWS      = 4;
  localparam int DEF_PERFECT_PTS = 3;
  localparam int DEF_GOOD_PTS    = 1;

  typedef enum logic [1:0] {
    GRADE_NONE    = 2'd0,
    GRADE_PERFECT = 2'd1,
    GRADE_GOOD    = 2'd2,
    GRADE_MISS    = 2'd3
  } grade_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/arrow_judge_btn_edge_detect.sv
// Two-flop button history with a rising-edge output, one bit per arrow lane.
module arrow_judge_btn_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_rise
);

  logic [WIDTH-1:0] btn_q;
  logic [WIDTH-1:0] btn_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= '0;
      btn_qq <= '0;
    end else begin
      btn_q  <= btn;
      btn_qq <= btn_q;
    end
  end

  assign btn_rise = btn_q & ~btn_qq;

endmodule

// File: rtl/arrow_judge.sv
// Grades each beat's arrow PERFECT/GOOD/MISS from player button edges and
// keeps score and combo. Define ARROW_JUDGE_MAX_COMBO_EN to add max_combo.
module arrow_judge
  import arrow_judge_pkg::*;
#(
  parameter int NUM_ARROWS  = arrow_judge_pkg::NUM_ARROWS,
  parameter int PERFECT_CYC = 4,
  parameter int WINDOW_CYC  = 16,
  parameter int PERFECT_PTS = DEF_PERFECT_PTS,
  parameter int GOOD_PTS    = DEF_GOOD_PTS,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_tick,
  input  logic [3:0]            arrow_in,
  input  logic [NUM_ARROWS-1:0] btn,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic [1:0]            grade,
  output logic [SCORE_W-1:0]    score,
  output logic [COMBO_W-1:0]    combo,
  output logic                  active
`ifdef ARROW_JUDGE_MAX_COMBO_EN
  ,
  output logic [COMBO_W-1:0]    max_combo
`endif
);

  localparam int CNT_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;

  state_t                state;
  logic [3:0]            tgt;
  logic [CNT_W-1:0]      win_cnt;
  logic [NUM_ARROWS-1:0] btn_rise;
  logic [NUM_ARROWS-1:0] tgt_mask;
  logic                  early;
  logic                  timeout;
  logic                  arrow_valid;
  logic [SCORE_W:0]      pts;
  logic [SCORE_W:0]      score_sum;
  logic [SCORE_W-1:0]    score_next;
  logic [COMBO_W-1:0]    combo_next;

  arrow_judge_btn_edge_detect #(
    .WIDTH(NUM_ARROWS)
  ) u_btn_edge_detect (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .btn_rise(btn_rise)
  );

  // Saturating score/combo candidates for a hit in the current cycle.
  always_comb begin
    tgt_mask    = NUM_ARROWS'(1) << tgt;
    early       = int'(win_cnt) < PERFECT_CYC;
    timeout     = (win_cnt == CNT_W'(WINDOW_CYC - 1));
    arrow_valid = int'(arrow_in) < NUM_ARROWS;
    pts         = early ? (SCORE_W + 1)'(PERFECT_PTS) : (SCORE_W + 1)'(GOOD_PTS);
    score_sum   = {1'b0, score} + pts;
    score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_next  = (&combo) ? combo : combo + COMBO_W'(1);
  end

  assign active = (state == ST_WINDOW);

  // The outgoing arrow is judged before a new beat's latch, so one cycle can
  // carry both the old arrow's pulse and the new arrow's capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tgt        <= '0;
      win_cnt    <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      grade      <= GRADE_NONE;
      score      <= '0;
      combo      <= '0;
`ifdef ARROW_JUDGE_MAX_COMBO_EN
      max_combo  <= '0;
`endif
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (state == ST_WINDOW) begin
        if (btn_rise == tgt_mask) begin
          hit_pulse <= 1'b1;
          grade     <= early ? GRADE_PERFECT : GRADE_GOOD;
          score     <= score_next;
          combo     <= combo_next;
`ifdef ARROW_JUDGE_MAX_COMBO_EN
          if (combo_next > max_combo) max_combo <= combo_next;
`endif
          state     <= ST_LOCKED;
        end else if ((btn_rise != '0) || beat_tick || timeout) begin
          miss_pulse <= 1'b1;
          grade      <= GRADE_MISS;
          combo      <= '0;
          state      <= ST_LOCKED;
        end else begin
          win_cnt <= win_cnt + CNT_W'(1);
        end
      end
      if (beat_tick) begin
        if (arrow_valid) begin
          tgt     <= arrow_in;
          win_cnt <= '0;
          state   <= ST_WINDOW;
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule
